// File: rtl/onehot_pulse_decoder.sv
// Encoded-index to one-hot pulse decoder: each accepted in-range index holds its
// output line high for PULSE_LEN cycles, with completion/error strobes and a dispatch count.
module onehot_pulse_decoder #(
  parameter int N_OUT     = 4,
  parameter int IDX_W     = 2,
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  output logic               in_ready,
  output logic [N_OUT-1:0]   out_onehot,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cmd_count
);

  localparam int            CW      = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CW-1:0] LAST    = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] PRELAST = CW'((PULSE_LEN > 1) ? PULSE_LEN - 2 : 0);
  localparam logic [IDX_W:0] N_LIM  = (IDX_W + 1)'(N_OUT);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [N_OUT-1:0]   r_onehot;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_last;
  logic               w_accept;
  logic               w_in_range;
  logic [N_OUT-1:0]   w_dec;

  function automatic logic [N_OUT-1:0] decode_idx(input logic [IDX_W-1:0] idx);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // The final pulse cycle doubles as an accept slot so pulses can abut with no gap.
  assign w_last     = (r_state == S_ACTIVE) && (r_cnt == LAST);
  assign in_ready   = !rst && ((r_state == S_IDLE) || w_last);
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = {1'b0, in_idx} < N_LIM;
  assign w_dec      = decode_idx(in_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_accept && w_in_range) begin
        r_state  <= S_ACTIVE;
        r_cnt    <= '0;
        r_onehot <= w_dec;
        r_busy   <= 1'b1;
        r_done   <= (PULSE_LEN == 1);
        r_count  <= r_count + CNT_W'(1);
      end else if (w_accept) begin
        // Out-of-range command: flag it and leave all lines low.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_onehot <= '0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_err    <= 1'b1;
      end else if (r_state == S_ACTIVE) begin
        if (w_last) begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_onehot <= '0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
          r_done <= (r_cnt == PRELAST);
        end
      end
    end
  end

  assign out_onehot = r_onehot;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign cmd_count  = r_count;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: instance A (N_OUT=5, PULSE_LEN=4) and instance B (N_OUT=4, PULSE_LEN=1).
module tb_onehot_pulse_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_valid = 1'b0;
  logic [2:0] a_idx = '0;
  logic       a_ready, a_busy, a_done, a_err;
  logic [4:0] a_oh;
  logic [7:0] a_cnt;

  logic       b_rst = 1'b1, b_valid = 1'b0;
  logic [1:0] b_idx = '0;
  logic       b_ready, b_busy, b_done, b_err;
  logic [3:0] b_oh;
  logic [7:0] b_cnt;

  int total = 0;
  int bad   = 0;

  onehot_pulse_decoder #(.N_OUT(5), .IDX_W(3), .PULSE_LEN(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_idx(a_idx), .in_ready(a_ready),
    .out_onehot(a_oh), .busy(a_busy), .done(a_done), .err(a_err), .cmd_count(a_cnt));

  onehot_pulse_decoder #(.N_OUT(4), .IDX_W(2), .PULSE_LEN(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_idx(b_idx), .in_ready(b_ready),
    .out_onehot(b_oh), .busy(b_busy), .done(b_done), .err(b_err), .cmd_count(b_cnt));

  // Reference model: each pulse is a window [m_start, m_end] of absolute cycle numbers.
  int cyc = 0;
  int m_line[2]  = '{-1, -1};
  int m_start[2] = '{0, 0};
  int m_end[2]   = '{-1, -1};
  int m_err[2]   = '{-5, -5};
  int m_count[2] = '{0, 0};

  function automatic int pl_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int n_of(input int i);
    return (i == 0) ? 5 : 4;
  endfunction

  function automatic bit m_ready(input int i, input logic r);
    return !r && (cyc >= m_end[i]);
  endfunction

  function automatic logic [15:0] exp_oh(input int i);
    if (cyc >= m_start[i] && cyc <= m_end[i] && m_line[i] >= 0) return 16'd1 << m_line[i];
    return 16'd0;
  endfunction

  task automatic model_edge(input int i, input logic r, input logic v, input int idx);
    if (r) begin
      m_line[i] = -1; m_start[i] = cyc + 1; m_end[i] = cyc; m_err[i] = -5; m_count[i] = 0;
    end else if (v && m_ready(i, r)) begin
      if (idx < n_of(i)) begin
        m_line[i] = idx; m_start[i] = cyc + 1; m_end[i] = cyc + pl_of(i);
        m_count[i] = (m_count[i] + 1) % 256;
      end else begin
        m_err[i] = cyc + 1;
      end
    end
  endtask

  // Clock edge consumes the currently driven inputs, then the given inputs are presented.
  task automatic tick(input logic ar, input logic av, input int ai,
                      input logic br, input logic bv, input int bi);
    @(posedge clk);
    model_edge(0, a_rst, a_valid, int'(a_idx));
    model_edge(1, b_rst, b_valid, int'(b_idx));
    cyc++;
    #1;
    a_rst = ar; a_valid = av; a_idx = 3'(ai);
    b_rst = br; b_valid = bv; b_idx = 2'(bi);
    #1;
  endtask

  task automatic tick_a(input logic ar, input logic av, input int ai);
    tick(ar, av, ai, 1'b0, 1'b0, 0);
  endtask

  task automatic tick_b(input logic br, input logic bv, input int bi);
    tick(1'b0, 1'b0, 0, br, bv, bi);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 2, 1'b1, 1'b1, 1);
    total++; if (a_oh !== 5'b0) begin bad++; $display("FAIL rst_a_oh got=%b exp=%b", a_oh, 5'b0); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_a_busy got=%b exp=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_a_done got=%b exp=0", a_done); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_a_err got=%b exp=0", a_err); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL rst_a_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    total++; if (b_oh !== 4'b0) begin bad++; $display("FAIL rst_b_oh got=%b exp=%b", b_oh, 4'b0); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
    total++; if (b_cnt !== 8'd0) begin bad++; $display("FAIL rst_b_cnt got=%0d exp=0", b_cnt); end
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    total++; if (a_oh !== 5'b0) begin bad++; $display("FAIL rst_rel_a_oh got=%b exp=%b", a_oh, 5'b0); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_a_ready got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_b_ready got=%b exp=1", b_ready); end
  endtask

  task automatic test_single;
    tick_a(1'b0, 1'b1, 2);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", a_ready); end
    for (int j = 1; j <= 5; j++) begin
      logic [4:0] e_oh;
      tick_a(1'b0, 1'b0, 0);
      e_oh = (j <= 4) ? 5'b00100 : 5'b00000;
      total++; if (a_oh !== e_oh) begin bad++; $display("FAIL single_oh c%0d got=%b exp=%b", j, a_oh, e_oh); end
      total++; if (a_busy !== (j <= 4)) begin bad++; $display("FAIL single_busy c%0d got=%b exp=%b", j, a_busy, (j <= 4)); end
      total++; if (a_done !== (j == 4)) begin bad++; $display("FAIL single_done c%0d got=%b exp=%b", j, a_done, (j == 4)); end
      total++; if (a_ready !== (j >= 4)) begin bad++; $display("FAIL single_ready c%0d got=%b exp=%b", j, a_ready, (j >= 4)); end
      total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt c%0d got=%0d exp=1", j, a_cnt); end
    end
  endtask

  task automatic test_back_to_back;
    tick_a(1'b0, 1'b1, 1);
    for (int j = 1; j <= 9; j++) begin
      logic [4:0] e_oh;
      logic [7:0] e_cnt;
      tick_a(1'b0, (j <= 4), 3);
      e_oh  = (j <= 4) ? 5'b00010 : (j <= 8) ? 5'b01000 : 5'b00000;
      e_cnt = (j <= 4) ? 8'd2 : 8'd3;
      total++; if (a_oh !== e_oh) begin bad++; $display("FAIL b2b_oh c%0d got=%b exp=%b", j, a_oh, e_oh); end
      total++; if (a_done !== (j == 4 || j == 8)) begin bad++; $display("FAIL b2b_done c%0d got=%b exp=%b", j, a_done, (j == 4 || j == 8)); end
      total++; if (a_ready !== (j == 4 || j >= 8)) begin bad++; $display("FAIL b2b_ready c%0d got=%b exp=%b", j, a_ready, (j == 4 || j >= 8)); end
      total++; if (a_cnt !== e_cnt) begin bad++; $display("FAIL b2b_cnt c%0d got=%0d exp=%0d", j, a_cnt, e_cnt); end
    end
  endtask

  task automatic test_same_idx;
    tick_a(1'b0, 1'b1, 0);
    for (int j = 1; j <= 9; j++) begin
      logic [4:0] e_oh;
      logic [7:0] e_cnt;
      tick_a(1'b0, (j <= 4), 0);
      e_oh  = (j <= 8) ? 5'b00001 : 5'b00000;
      e_cnt = (j <= 4) ? 8'd4 : 8'd5;
      total++; if (a_oh !== e_oh) begin bad++; $display("FAIL same_oh c%0d got=%b exp=%b", j, a_oh, e_oh); end
      total++; if (a_busy !== (j <= 8)) begin bad++; $display("FAIL same_busy c%0d got=%b exp=%b", j, a_busy, (j <= 8)); end
      total++; if (a_done !== (j == 4 || j == 8)) begin bad++; $display("FAIL same_done c%0d got=%b exp=%b", j, a_done, (j == 4 || j == 8)); end
      total++; if (a_cnt !== e_cnt) begin bad++; $display("FAIL same_cnt c%0d got=%0d exp=%0d", j, a_cnt, e_cnt); end
    end
  endtask

  task automatic test_out_of_range;
    tick_a(1'b0, 1'b1, 6);
    tick_a(1'b0, 1'b0, 0);
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", a_err); end
    total++; if (a_oh !== 5'b0) begin bad++; $display("FAIL oor_oh got=%b exp=%b", a_oh, 5'b0); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL oor_busy got=%b exp=0", a_busy); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b exp=1", a_ready); end
    total++; if (a_cnt !== 8'd5) begin bad++; $display("FAIL oor_cnt got=%0d exp=5", a_cnt); end
    tick_a(1'b0, 1'b0, 0);
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL oor_err_drop got=%b exp=0", a_err); end
    // Out-of-range command held across a pulse and taken in its final cycle.
    tick_a(1'b0, 1'b1, 2);
    for (int j = 1; j <= 6; j++) begin
      logic [4:0] e_oh;
      tick_a(1'b0, (j <= 4), 7);
      e_oh = (j <= 4) ? 5'b00100 : 5'b00000;
      total++; if (a_oh !== e_oh) begin bad++; $display("FAIL oorl_oh c%0d got=%b exp=%b", j, a_oh, e_oh); end
      total++; if (a_done !== (j == 4)) begin bad++; $display("FAIL oorl_done c%0d got=%b exp=%b", j, a_done, (j == 4)); end
      total++; if (a_err !== (j == 5)) begin bad++; $display("FAIL oorl_err c%0d got=%b exp=%b", j, a_err, (j == 5)); end
      total++; if (a_cnt !== 8'd6) begin bad++; $display("FAIL oorl_cnt c%0d got=%0d exp=6", j, a_cnt); end
    end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL oorl_ready got=%b exp=1", a_ready); end
  endtask

  task automatic test_reset_mid;
    tick_a(1'b0, 1'b1, 3);
    tick_a(1'b0, 1'b0, 0);
    total++; if (a_oh !== 5'b01000) begin bad++; $display("FAIL rmid_oh1 got=%b exp=%b", a_oh, 5'b01000); end
    tick_a(1'b1, 1'b0, 0);
    total++; if (a_oh !== 5'b01000) begin bad++; $display("FAIL rmid_oh2 got=%b exp=%b", a_oh, 5'b01000); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_rst got=%b exp=0", a_ready); end
    tick_a(1'b1, 1'b0, 0);
    total++; if (a_oh !== 5'b0) begin bad++; $display("FAIL rmid_oh3 got=%b exp=%b", a_oh, 5'b0); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", a_busy); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_rst2 got=%b exp=0", a_ready); end
    for (int j = 0; j < 4; j++) begin
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rmid_done c%0d got=%b exp=0", j, a_done); end
      tick_a(1'b0, 1'b0, 0);
    end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b exp=1", a_ready); end
  endtask

  task automatic test_pulse1;
    for (int j = 0; j <= 257; j++) begin
      logic [3:0] e_oh;
      tick_b(1'b0, (j < 256), j % 4);
      if (j >= 1) begin
        e_oh = (j <= 256) ? (4'b0001 << ((j - 1) % 4)) : 4'b0000;
        total++; if (b_oh !== e_oh) begin bad++; $display("FAIL p1_oh c%0d got=%b exp=%b", j, b_oh, e_oh); end
        total++; if (b_done !== (j <= 256)) begin bad++; $display("FAIL p1_done c%0d got=%b exp=%b", j, b_done, (j <= 256)); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL p1_ready c%0d got=%b exp=1", j, b_ready); end
        total++; if (b_cnt !== 8'((j > 256 ? 256 : j) % 256)) begin bad++; $display("FAIL p1_cnt c%0d got=%0d exp=%0d", j, b_cnt, (j > 256 ? 256 : j) % 256); end
      end
    end
  endtask

  task automatic test_random;
    logic nar, nav, nbr, nbv;
    int   nai, nbi;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ea, eb;
      nar = ($urandom_range(0, 59) == 0);
      nbr = ($urandom_range(0, 59) == 0);
      if (!a_valid || m_ready(0, a_rst)) begin
        nav = ($urandom_range(0, 2) != 0); nai = $urandom_range(0, 7);
      end else begin
        nav = a_valid; nai = int'(a_idx);
      end
      if (!b_valid || m_ready(1, b_rst)) begin
        nbv = ($urandom_range(0, 2) != 0); nbi = $urandom_range(0, 3);
      end else begin
        nbv = b_valid; nbi = int'(b_idx);
      end
      tick(nar, nav, nai, nbr, nbv, nbi);
      ea = exp_oh(0);
      eb = exp_oh(1);
      total++; if (a_oh !== ea[4:0]) begin bad++; $display("FAIL rnd_a_oh cyc=%0d got=%b exp=%b", cyc, a_oh, ea[4:0]); end
      total++; if (a_busy !== (ea != 0)) begin bad++; $display("FAIL rnd_a_busy cyc=%0d got=%b exp=%b", cyc, a_busy, (ea != 0)); end
      total++; if (a_done !== (ea != 0 && cyc == m_end[0])) begin bad++; $display("FAIL rnd_a_done cyc=%0d got=%b", cyc, a_done); end
      total++; if (a_err !== (cyc == m_err[0])) begin bad++; $display("FAIL rnd_a_err cyc=%0d got=%b exp=%b", cyc, a_err, (cyc == m_err[0])); end
      total++; if (a_ready !== m_ready(0, a_rst)) begin bad++; $display("FAIL rnd_a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, m_ready(0, a_rst)); end
      total++; if (a_cnt !== 8'(m_count[0])) begin bad++; $display("FAIL rnd_a_cnt cyc=%0d got=%0d exp=%0d", cyc, a_cnt, m_count[0]); end
      total++; if (b_oh !== eb[3:0]) begin bad++; $display("FAIL rnd_b_oh cyc=%0d got=%b exp=%b", cyc, b_oh, eb[3:0]); end
      total++; if (b_done !== (eb != 0 && cyc == m_end[1])) begin bad++; $display("FAIL rnd_b_done cyc=%0d got=%b", cyc, b_done); end
      total++; if (b_ready !== m_ready(1, b_rst)) begin bad++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, m_ready(1, b_rst)); end
      total++; if (b_cnt !== 8'(m_count[1])) begin bad++; $display("FAIL rnd_b_cnt cyc=%0d got=%0d exp=%0d", cyc, b_cnt, m_count[1]); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_same_idx;
    test_out_of_range;
    test_reset_mid;
    test_pulse1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
